// File: rtl/oflow_core_fsm_read.sv
`default_nettype none
// ============================================================================
//  Module   : oflow_core_fsm_read
//  Purpose  : Read-side sequencer for the core MEM buffer. Fetches a frame's
//             bounding boxes one set (up to PE_NUM bboxes) at a time, packed
//             BBOX_PER_WORD per buffer word. It issues buffer reads and steers
//             the returned words into PE groups with a per-bbox valid mask.
//             Before each set it waits for core_ready, so a set can load while
//             the previous one is processed.
//  Ports    : clk, reset                 - clock, sync active-high reset
//             start_read, num_of_bbox_in_frame - frame start and bbox count
//             core_ready                 - core can take the next set
//             rd_en, rd_addr             - buffer read strobe / word address
//             load_pe, pe_sel, bbox_mask - read data qualifiers for the PEs
//             row_sel                    - current set index
//             set_done, done_read, busy  - status pulses / level
//  Revision : 1.0 - initial release
// ============================================================================
module oflow_core_fsm_read #(
  parameter int PE_NUM        = 24,
  parameter int BBOX_PER_WORD = 4,
  parameter int NUM_BBOX_W    = 7,
  parameter int ADDR_W        = 5,
  parameter int SET_W         = 3,
  parameter int RD_LAT        = 1,
  localparam int GRPS         = PE_NUM / BBOX_PER_WORD,
  localparam int SEL_W        = (GRPS > 1) ? $clog2(GRPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_read,
  input  logic [NUM_BBOX_W-1:0]    num_of_bbox_in_frame,
  input  logic                     core_ready,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     load_pe,
  output logic [SEL_W-1:0]         pe_sel,
  output logic [BBOX_PER_WORD-1:0] bbox_mask,
  output logic [SET_W-1:0]         row_sel,
  output logic                     set_done,
  output logic                     done_read,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CORE = 3'd1,
    S_ISSUE     = 3'd2,
    S_DRAIN     = 3'd3,
    S_SET_END   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [NUM_BBOX_W-1:0] BPW_C      = NUM_BBOX_W'(BBOX_PER_WORD);
  localparam logic [SEL_W-1:0]      LAST_GRP_C = SEL_W'(GRPS - 1);
  localparam logic [1:0]            DRAIN_LAST = 2'(RD_LAT - 1);

  state_t                  state_q;
  logic [NUM_BBOX_W-1:0]   rem_q;
  logic [ADDR_W-1:0]       word_cnt_q;
  logic [SEL_W-1:0]        grp_cnt_q;
  logic [SET_W-1:0]        row_cnt_q;
  logic [1:0]              drain_cnt_q;
  logic                    rd_en_q;
  logic                    set_done_q;
  logic                    done_read_q;
  logic                    busy_q;

  // Per-word issue values derived from the remaining count
  logic [BBOX_PER_WORD-1:0] mask_d;
  logic [NUM_BBOX_W-1:0]    rem_d;
  logic                     last_issue_d;

  always_comb begin
    mask_d = '0;
    // Bit i is valid when more than i bboxes remain: yields (1<<n)-1
    for (int i = 0; i < BBOX_PER_WORD; i++) begin
      mask_d[i] = (rem_q > NUM_BBOX_W'(i));
    end
    rem_d        = (rem_q > BPW_C) ? (rem_q - BPW_C) : '0;
    last_issue_d = (grp_cnt_q == LAST_GRP_C) || (rem_q <= BPW_C);
  end

  // --------------------------------------------------------------------------
  // Sequencer; all outputs registered alongside the state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      word_cnt_q  <= '0;
      grp_cnt_q   <= '0;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      set_done_q  <= 1'b0;
      done_read_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      set_done_q  <= 1'b0;
      done_read_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_read) begin
            rem_q      <= num_of_bbox_in_frame;
            word_cnt_q <= '0;
            grp_cnt_q  <= '0;
            row_cnt_q  <= '0;
            busy_q     <= 1'b1;
            if (num_of_bbox_in_frame == '0) begin
              state_q     <= S_DONE;
              done_read_q <= 1'b1;
            end else begin
              state_q <= S_WAIT_CORE;
            end
          end
        end
        S_WAIT_CORE: begin
          if (core_ready) begin
            state_q <= S_ISSUE;
            rd_en_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          rem_q      <= rem_d;
          word_cnt_q <= word_cnt_q + ADDR_W'(1);
          grp_cnt_q  <= grp_cnt_q + SEL_W'(1);
          if (last_issue_d) begin
            state_q     <= S_DRAIN;
            rd_en_q     <= 1'b0;
            drain_cnt_q <= '0;
          end
        end
        S_DRAIN: begin
          // Hold until the final read of the set has left the load pipeline
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q    <= S_SET_END;
            set_done_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        S_SET_END: begin
          grp_cnt_q <= '0;
          if (rem_q == '0) begin
            state_q     <= S_DONE;
            done_read_q <= 1'b1;
          end else begin
            row_cnt_q <= row_cnt_q + SET_W'(1);
            state_q   <= S_WAIT_CORE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Load pipeline: matches the buffer read latency. Group and mask are zeroed
  // when no read was issued so idle cycles present clean qualifiers.
  // --------------------------------------------------------------------------
  logic [RD_LAT-1:0]        pipe_vld_q;
  logic [SEL_W-1:0]         pipe_sel_q  [RD_LAT];
  logic [BBOX_PER_WORD-1:0] pipe_mask_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_sel_q[i]  <= '0;
        pipe_mask_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0]  <= rd_en_q;
      pipe_sel_q[0]  <= rd_en_q ? grp_cnt_q : '0;
      pipe_mask_q[0] <= rd_en_q ? mask_d : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_sel_q[i]  <= pipe_sel_q[i-1];
        pipe_mask_q[i] <= pipe_mask_q[i-1];
      end
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = word_cnt_q;
  assign load_pe   = pipe_vld_q[RD_LAT-1];
  assign pe_sel    = pipe_sel_q[RD_LAT-1];
  assign bbox_mask = pipe_mask_q[RD_LAT-1];
  assign row_sel   = row_cnt_q;
  assign set_done  = set_done_q;
  assign done_read = done_read_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
